// File: rtl/snake_game_core.sv
// Snake game state machine: a synchronized frame clock paces moves, the core handles
// steering, collision, growth, score and LFSR-driven apple placement.
module snake_game_core #(
    parameter int STEP_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_clk,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_start,
    output logic [71:0] snake,
    output logic [7:0]  apple,
    output logic [7:0]  barrier,
    output logic [3:0]  length,
    output logic [7:0]  score,
    output logic        game_over,
    output logic [1:0]  state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_APPLE = 2'd2;
    localparam logic [1:0] S_OVER  = 2'd3;

    // Encoding chosen so that the opposite direction is d ^ 1.
    localparam logic [1:0] D_UP    = 2'd0;
    localparam logic [1:0] D_DOWN  = 2'd1;
    localparam logic [1:0] D_LEFT  = 2'd2;
    localparam logic [1:0] D_RIGHT = 2'd3;

    localparam logic [7:0] BARRIER   = 8'd77;
    localparam logic [7:0] APPLE_INI = 8'd33;
    localparam logic [7:0] STEP_LAST = 8'(STEP_FRAMES - 1);

    logic [7:0] seg [9];
    logic       frame_s1, frame_s2, frame_s3;
    logic       frame_event;
    logic [7:0] frame_cnt;
    logic       step_q;
    logic       pending;
    logic [7:0] lfsr;
    logic [1:0] dir;
    logic [1:0] last_move;
    logic [1:0] move_ref;
    logic [1:0] req;
    logic       req_valid;
    logic       do_step;
    logic       restart;
    logic [7:0] next_head;
    logic       eating;
    logic [3:0] hit_limit;
    logic       body_hit;
    logic       collide;
    logic [3:0] new_len;
    logic [7:0] cand;
    logic       cand_clear;

    function automatic logic [7:0] init_seg(input int i);
        return (i < 3) ? 8'(55 - i) : 8'd0;
    endfunction

    function automatic logic in_field(input logic [7:0] c);
        logic [7:0] col;
        col = c % 8'd10;
        return (c >= 8'd12) && (c <= 8'd89) && (col >= 8'd2);
    endfunction

    for (genvar g = 0; g < 9; g++) begin : g_pack
        assign snake[71-8*g -: 8] = seg[g];
    end

    assign barrier     = BARRIER;
    assign game_over   = (state == S_OVER);
    assign frame_event = frame_s2 & ~frame_s3;
    assign do_step     = (state == S_RUN) && (step_q || pending);
    assign restart     = (state == S_OVER) && btn_start;
    assign move_ref    = do_step ? dir : last_move;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_s1  <= 1'b0;
            frame_s2  <= 1'b0;
            frame_s3  <= 1'b0;
            frame_cnt <= 8'd0;
            step_q    <= 1'b0;
        end else begin
            frame_s1 <= frame_clk;
            frame_s2 <= frame_s1;
            frame_s3 <= frame_s2;
            step_q   <= 1'b0;
            if (state != S_RUN) begin
                frame_cnt <= 8'd0;
            end else if (frame_event) begin
                if (frame_cnt == STEP_LAST) begin
                    frame_cnt <= 8'd0;
                    step_q    <= 1'b1;
                end else begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr <= 8'hA5;
        else      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    always_comb begin
        req_valid = 1'b1;
        req       = D_RIGHT;
        if (btn_up)         req = D_UP;
        else if (btn_down)  req = D_DOWN;
        else if (btn_left)  req = D_LEFT;
        else if (btn_right) req = D_RIGHT;
        else                req_valid = 1'b0;
    end

    // A reversal is judged against the move that actually happened, not the pending one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                        dir <= D_RIGHT;
        else if (restart)                                dir <= D_RIGHT;
        else if (req_valid && (req != (move_ref ^ 2'b01))) dir <= req;
    end

    always_comb begin
        case (dir)
            D_UP:    next_head = seg[0] - 8'd10;
            D_DOWN:  next_head = seg[0] + 8'd10;
            D_LEFT:  next_head = seg[0] - 8'd1;
            default: next_head = seg[0] + 8'd1;
        endcase
        eating    = (apple != 8'd0) && (next_head == apple);
        // The tail vacates its cell on a plain move, but stays put when growing.
        hit_limit = eating ? (length - 4'd1) : (length - 4'd2);
        body_hit  = 1'b0;
        for (int i = 1; i < 9; i++) begin
            if ((4'(i) <= hit_limit) && (seg[i] == next_head)) body_hit = 1'b1;
        end
        collide = !in_field(next_head) || (next_head == BARRIER) || body_hit;
        new_len = (eating && (length != 4'd9)) ? (length + 4'd1) : length;
    end

    always_comb begin
        cand = 8'd10 * ({5'd0, lfsr[2:0]} + 8'd1) + {5'd0, lfsr[5:3]} + 8'd2;
        cand_clear = (cand != BARRIER);
        for (int i = 0; i < 9; i++) begin
            if ((4'(i) < length) && (seg[i] == cand)) cand_clear = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            length    <= 4'd3;
            apple     <= APPLE_INI;
            score     <= 8'd0;
            pending   <= 1'b0;
            last_move <= D_RIGHT;
            for (int i = 0; i < 9; i++) seg[i] <= init_seg(i);
        end else begin
            case (state)
                S_IDLE: begin
                    if (btn_start) state <= S_RUN;
                end
                S_RUN: begin
                    if (do_step) begin
                        pending <= 1'b0;
                        if (collide) begin
                            state <= S_OVER;
                        end else begin
                            last_move <= dir;
                            seg[0]    <= next_head;
                            for (int i = 1; i < 9; i++) begin
                                seg[i] <= (4'(i) < new_len) ? seg[i-1] : 8'd0;
                            end
                            length <= new_len;
                            if (eating) begin
                                if (score != 8'hFF) score <= score + 8'd1;
                                apple <= 8'd0;
                                state <= S_APPLE;
                            end
                        end
                    end
                end
                S_APPLE: begin
                    if (step_q) pending <= 1'b1;
                    if (cand_clear) begin
                        apple <= cand;
                        state <= S_RUN;
                    end
                end
                default: begin
                    if (btn_start) begin
                        state     <= S_IDLE;
                        length    <= 4'd3;
                        apple     <= APPLE_INI;
                        score     <= 8'd0;
                        pending   <= 1'b0;
                        last_move <= D_RIGHT;
                        for (int i = 0; i < 9; i++) seg[i] <= init_seg(i);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_game_core.sv
// Directed bench for snake_game_core: a vector table of button/frame actions with
// hand-computed board states, plus sequences for eating, reset in APPLE and step timing.
module tb_snake_game_core;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_APPLE = 2'd2;
    localparam logic [1:0] S_OVER  = 2'd3;

    // Button vector bits: {up, down, left, right, start}
    localparam logic [4:0] B_NONE  = 5'b00000;
    localparam logic [4:0] B_UP    = 5'b10000;
    localparam logic [4:0] B_DOWN  = 5'b01000;
    localparam logic [4:0] B_LEFT  = 5'b00100;
    localparam logic [4:0] B_RIGHT = 5'b00010;
    localparam logic [4:0] B_START = 5'b00001;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_clk = 1'b0;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        btn_start = 1'b0;
    logic [71:0] snake;
    logic [7:0]  apple;
    logic [7:0]  barrier;
    logic [3:0]  length;
    logic [7:0]  score;
    logic        game_over;
    logic [1:0]  state;

    int total = 0;
    int bad = 0;
    logic [71:0] exp_q[$];

    typedef struct {
        logic        do_rst;
        logic [4:0]  btn;
        int          nev;
        logic [71:0] exp_snake;
        logic [7:0]  exp_apple;
        logic [3:0]  exp_len;
        logic [7:0]  exp_score;
        logic [1:0]  exp_state;
    } vec_t;

    vec_t vecs[13];

    snake_game_core #(.STEP_FRAMES(8)) dut (
        .clk(clk), .rst(rst), .frame_clk(frame_clk),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_start(btn_start),
        .snake(snake), .apple(apple), .barrier(barrier), .length(length),
        .score(score), .game_over(game_over), .state(state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    function automatic logic [71:0] pk(input logic [7:0] h, input logic [7:0] s1,
                                       input logic [7:0] s2, input logic [7:0] s3);
        return {h, s1, s2, s3, 40'd0};
    endfunction

    function automatic logic cell_ok(input logic [7:0] a);
        int row;
        int col;
        row = int'(a) / 10;
        col = int'(a) % 10;
        return (row >= 1) && (row <= 8) && (col >= 2) && (col <= 9);
    endfunction

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [4:0] b);
        {btn_up, btn_down, btn_left, btn_right, btn_start} = b;
        tick(1);
        {btn_up, btn_down, btn_left, btn_right, btn_start} = B_NONE;
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            frame_clk = 1'b1;
            tick(4);
            frame_clk = 1'b0;
            tick(4);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
    endtask

    // Scoreboard
    task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic check_board(input string tag, input logic [71:0] e_snake,
                               input logic [7:0] e_apple, input logic [3:0] e_len,
                               input logic [7:0] e_score, input logic [1:0] e_state);
        check({tag, "_snake"}, snake, e_snake);
        check({tag, "_apple"}, 72'(apple), 72'(e_apple));
        check({tag, "_len"}, 72'(length), 72'(e_len));
        check({tag, "_score"}, 72'(score), 72'(e_score));
        check({tag, "_state"}, 72'(state), 72'(e_state));
        check({tag, "_go"}, 72'(game_over), 72'(e_state == S_OVER));
        check({tag, "_barrier"}, 72'(barrier), 72'd77);
    endtask

    // Drives the fixed path reset -> up -> left -> left -> up, stopping with frame_clk
    // high on the final frame so the caller can watch the step that eats apple 33.
    task automatic path_to_apple();
        do_reset();
        press(B_START | B_UP);
        frames(8);
        check("path_up", 72'(snake[71:64]), 72'd45);
        press(B_LEFT);
        frames(16);
        check("path_left", snake, pk(43, 44, 45, 0));
        press(B_UP);
        frames(7);
        frame_clk = 1'b1;
    endtask

    initial begin
        // Scenario A: idle, run into the right wall, restart. Scenario B: up+right priority,
        // steer into the barrier.
        vecs[0]  = '{1'b0, B_NONE,  20, pk(55, 54, 53, 0), 8'd33, 4'd3, 8'd0, S_IDLE};
        vecs[1]  = '{1'b0, B_START,  0, pk(55, 54, 53, 0), 8'd33, 4'd3, 8'd0, S_RUN};
        vecs[2]  = '{1'b0, B_LEFT,   8, pk(56, 55, 54, 0), 8'd33, 4'd3, 8'd0, S_RUN};
        vecs[3]  = '{1'b0, B_NONE,  16, pk(58, 57, 56, 0), 8'd33, 4'd3, 8'd0, S_RUN};
        vecs[4]  = '{1'b0, B_NONE,   8, pk(59, 58, 57, 0), 8'd33, 4'd3, 8'd0, S_RUN};
        vecs[5]  = '{1'b0, B_NONE,   8, pk(59, 58, 57, 0), 8'd33, 4'd3, 8'd0, S_OVER};
        vecs[6]  = '{1'b0, B_START,  0, pk(55, 54, 53, 0), 8'd33, 4'd3, 8'd0, S_IDLE};
        vecs[7]  = '{1'b1, B_UP | B_RIGHT | B_START, 8, pk(45, 55, 54, 0), 8'd33, 4'd3, 8'd0, S_RUN};
        vecs[8]  = '{1'b0, B_RIGHT,  8, pk(46, 45, 55, 0), 8'd33, 4'd3, 8'd0, S_RUN};
        vecs[9]  = '{1'b0, B_NONE,   8, pk(47, 46, 45, 0), 8'd33, 4'd3, 8'd0, S_RUN};
        vecs[10] = '{1'b0, B_DOWN,   8, pk(57, 47, 46, 0), 8'd33, 4'd3, 8'd0, S_RUN};
        vecs[11] = '{1'b0, B_NONE,   8, pk(67, 57, 47, 0), 8'd33, 4'd3, 8'd0, S_RUN};
        vecs[12] = '{1'b0, B_NONE,   8, pk(67, 57, 47, 0), 8'd33, 4'd3, 8'd0, S_OVER};
        for (int i = 0; i < 13; i++) exp_q.push_back(vecs[i].exp_snake);

        // Reset values while rst is held low
        tick(1);
        check_board("reset", pk(55, 54, 53, 0), 8'd33, 4'd3, 8'd0, S_IDLE);
        rst = 1'b1;
        tick(1);

        for (int i = 0; i < 13; i++) begin
            logic [71:0] e_snake;
            if (vecs[i].do_rst) do_reset();
            if (vecs[i].btn != B_NONE) press(vecs[i].btn);
            frames(vecs[i].nev);
            e_snake = exp_q.pop_front();
            check_board($sformatf("vec%0d", i), e_snake, vecs[i].exp_apple,
                        vecs[i].exp_len, vecs[i].exp_score, vecs[i].exp_state);
        end

        // Step timing: no move on the 7th frame, move on the 8th; start held in RUN is ignored
        do_reset();
        press(B_START);
        btn_start = 1'b1;
        frames(7);
        check_board("step7", pk(55, 54, 53, 0), 8'd33, 4'd3, 8'd0, S_RUN);
        frames(1);
        check_board("step8", pk(56, 55, 54, 0), 8'd33, 4'd3, 8'd0, S_RUN);
        btn_start = 1'b0;

        // Eating apple 33: growth, score, hidden apple, then a fresh valid apple
        begin
            logic found;
            logic ok;
            path_to_apple();
            found = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (!found) begin
                    tick(1);
                    if (snake[71:64] == 8'd33) found = 1'b1;
                end
            end
            check("eat_seen", 72'(found), 72'd1);
            check_board("eat", pk(33, 43, 44, 45), 8'd0, 4'd4, 8'd1, S_APPLE);
            found = 1'b0;
            for (int k = 0; k < 64; k++) begin
                if (!found) begin
                    tick(1);
                    if (state == S_RUN) found = 1'b1;
                end
            end
            check("apple_search_done", 72'(found), 72'd1);
            ok = (apple != 8'd0) && (apple != 8'd77) && cell_ok(apple) &&
                 (apple != 8'd33) && (apple != 8'd43) && (apple != 8'd44) && (apple != 8'd45);
            check("apple_valid", 72'(ok), 72'd1);
            check("apple_len", 72'(length), 72'd4);
            frame_clk = 1'b0;
            tick(4);
        end

        // Reset asserted while in APPLE takes effect at once and drops any step
        begin
            logic found;
            path_to_apple();
            found = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (!found) begin
                    tick(1);
                    if (state == S_APPLE) found = 1'b1;
                end
            end
            check("apple_entered", 72'(found), 72'd1);
            rst = 1'b0;
            #1;
            check_board("rst_apple", pk(55, 54, 53, 0), 8'd33, 4'd3, 8'd0, S_IDLE);
            frame_clk = 1'b0;
            tick(2);
            rst = 1'b1;
            frames(16);
            check_board("after_rst", pk(55, 54, 53, 0), 8'd33, 4'd3, 8'd0, S_IDLE);
        end

        // Final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        bad++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
